// File: rtl/data_memory_bytelane.sv
// Byte-addressed RV32I data memory with byte-lane stores, load extension,
// valid/ready request side and a fixed-latency response pulse.
module data_memory_bytelane #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam bit FULL  = (IDX_W >= ADDR_W - 2);
    localparam logic [ADDR_W-3:0] NWORDS = (ADDR_W-2)'(DEPTH_WORDS);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic              accept;
    logic [ADDR_W-3:0] widx;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              size_bad, mis, oor, err;
    logic [3:0]        be;
    logic [31:0]       wdl, rword, rsh, ld, rdat;

    logic [LATENCY-1:0]       vld_q, err_q;
    logic [LATENCY-1:0][31:0] dat_q;

    assign accept = req_valid & req_ready & ~rst;
    assign widx   = req_addr[ADDR_W-1:2];
    assign idx    = req_addr[IDX_W+1:2];
    assign lane   = req_addr[1:0];

    always_comb begin
        size_bad = 1'b1;
        mis      = 1'b0;
        case (req_size)
            3'b000: size_bad = 1'b0;
            3'b001: begin size_bad = 1'b0; mis = lane[0]; end
            3'b010: begin size_bad = 1'b0; mis = |lane; end
            3'b100: size_bad = req_we;
            3'b101: begin size_bad = req_we; mis = lane[0]; end
            default: size_bad = 1'b1;
        endcase
    end

    assign oor = !FULL && (widx >= NWORDS);
    assign err = size_bad | mis | oor;

    always_comb begin
        case (req_size[1:0])
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
    end

    assign wdl = req_wdata << {lane, 3'b000};

    always_ff @(posedge CLK) begin
        if (accept && req_we && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdl[8*i +: 8];
        end
    end

    // Pre-edge word contents feed the response chain captured at accept.
    assign rword = mem[idx];
    assign rsh   = rword >> {lane, 3'b000};

    always_comb begin
        case (req_size)
            3'b000:  ld = {{24{rsh[7]}}, rsh[7:0]};
            3'b100:  ld = {24'b0, rsh[7:0]};
            3'b001:  ld = {{16{rsh[15]}}, rsh[15:0]};
            3'b101:  ld = {16'b0, rsh[15:0]};
            default: ld = rword;
        endcase
    end

    assign rdat = (err || req_we) ? 32'b0 : ld;

    always_ff @(posedge CLK) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q[0] <= accept;
            err_q[0] <= accept & err;
            dat_q[0] <= accept ? rdat : 32'b0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rsp_valid = vld_q[LATENCY-1];
    assign rsp_err   = err_q[LATENCY-1];
    assign rsp_rdata = dat_q[LATENCY-1];

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && LATENCY > 1) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 3'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Bench for data_memory_bytelane: LATENCY=1 and LATENCY=3 instances
// checked against a byte-array reference model.
module tb_data_memory_bytelane;

    localparam int DEPTH = 64;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst1, v1, we1, rdy1, rv1, er1;
    logic [2:0]  sz1;
    logic [31:0] ad1, wd1, rd1;

    logic        rst3, v3, we3, rdy3, rv3, er3;
    logic [2:0]  sz3;
    logic [31:0] ad3, wd3, rd3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [2][DEPTH*4];

    data_memory_bytelane #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
        .CLK(CLK), .rst(rst1), .req_valid(v1), .req_ready(rdy1),
        .req_we(we1), .req_size(sz1), .req_addr(ad1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
    );

    data_memory_bytelane #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u3 (
        .CLK(CLK), .rst(rst3), .req_valid(v3), .req_ready(rdy3),
        .req_we(we3), .req_size(sz3), .req_addr(ad3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input int inst, input logic we,
                                  input logic [2:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output logic e, output logic [31:0] rd);
        int n;
        logic [31:0] v;
        case (sz)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        e  = (n == 0) || (we && sz[2]);
        if (!e) e = ((a % n) != 0) || ((a >> 2) >= DEPTH);
        rd = 32'b0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < n; i++)
                mdl[inst][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'b0;
            for (int i = 0; i < n; i++)
                v[8*i +: 8] = mdl[inst][int'(a) + i];
            if (!sz[2] && n < 4 && v[8*n-1])
                v = v | (32'hFFFF_FFFF << (8*n));
            rd = v;
        end
    endfunction

    task automatic do1(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got);
        logic        e;
        logic [31:0] r;
        model(0, we, sz, a, wd, e, r);
        check("rdy1", rdy1, 1);
        v1 = 1; we1 = we; sz1 = sz; ad1 = a; wd1 = wd;
        @(posedge CLK); #1;
        v1 = 0;
        check("vld1", rv1, 1);
        check("err1", er1, e);
        check("dat1", rd1, r);
        got = rd1;
    endtask

    task automatic do3(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] got);
        logic        e;
        logic [31:0] r;
        model(1, we, sz, a, wd, e, r);
        check("rdy3_pre", rdy3, 1);
        v3 = 1; we3 = we; sz3 = sz; ad3 = a; wd3 = wd;
        @(posedge CLK); #1;
        we3 = 1; sz3 = 3'd2; ad3 = 32'h10; wd3 = $urandom;
        got = 32'hx;
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) begin @(posedge CLK); #1; end
            check("rdy3", rdy3, i == 3);
            check("vld3", rv3, i == 3);
            if (i == 3) begin
                check("err3", er3, e);
                check("dat3", rd3, r);
                got = rd3;
            end else begin
                check("dat3_idle", rd3, 0);
            end
        end
        v3 = 0;
    endtask

    initial begin
        #10000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        logic        e;
        logic [31:0] r;
        rst1 = 1; v1 = 0; we1 = 0; sz1 = 0; ad1 = 0; wd1 = 0;
        rst3 = 1; v3 = 0; we3 = 0; sz3 = 0; ad3 = 0; wd3 = 0;
        repeat (2) @(posedge CLK);
        #1;
        rst1 = 0; rst3 = 0;
        check("rst1_rdy", rdy1, 1);
        check("rst1_vld", rv1, 0);
        check("rst1_dat", rd1, 0);
        check("rst1_err", er1, 0);
        check("rst3_rdy", rdy3, 1);
        check("rst3_vld", rv3, 0);

        do1(1, 3'd2, 32'h1C, 32'h8765_4321, g);
        do1(0, 3'd2, 32'h1C, 0, g);
        check("lw_1c", g, 32'h8765_4321);

        do1(1, 3'd2, 32'h00, 32'h0102_0304, g);
        do1(1, 3'd2, 32'h28, 32'h0, g);
        do1(1, 3'd0, 32'h29, 32'h0000_0080, g);
        do1(1, 3'd1, 32'h2A, 32'h0000_BEEF, g);
        do1(0, 3'd2, 32'h28, 0, g); check("lw_28", g, 32'hBEEF_8000);
        do1(0, 3'd0, 32'h29, 0, g); check("lb_29", g, 32'hFFFF_FF80);
        do1(0, 3'd4, 32'h29, 0, g); check("lbu_29", g, 32'h0000_0080);
        do1(0, 3'd1, 32'h2A, 0, g); check("lh_2a", g, 32'hFFFF_BEEF);
        do1(0, 3'd5, 32'h2A, 0, g); check("lhu_2a", g, 32'h0000_BEEF);

        do1(0, 3'd2, 32'h2A, 0, g);
        check("e_lw_mis", er1, 1);
        do1(1, 3'd1, 32'h29, 32'h1234, g);
        check("e_sh_mis", er1, 1);
        do1(1, 3'd3, 32'h28, 32'hFFFF_FFFF, g);
        check("e_size3", er1, 1);
        do1(1, 3'd4, 32'h28, 32'hFFFF_FFFF, g);
        check("e_st_bu", er1, 1);
        do1(1, 3'd2, DEPTH * 4, 32'hDEAD_BEEF, g);
        check("e_oor", er1, 1);
        do1(0, 3'd2, 32'h28, 0, g); check("lw_28_kept", g, 32'hBEEF_8000);
        do1(0, 3'd2, 32'h00, 0, g); check("lw_00_kept", g, 32'h0102_0304);
        @(posedge CLK); #1;
        check("idle1_vld", rv1, 0);

        for (int w = 0; w < DEPTH; w++)
            do1(1, 3'd2, 32'(w * 4), $urandom, g);
        for (int t = 0; t < 300; t++)
            do1(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, DEPTH * 4 + 31)), $urandom, g);

        do3(1, 3'd2, 32'h10, 32'hCAFE_F00D, g);
        do3(1, 3'd2, 32'h20, 32'h0, g);
        do3(1, 3'd2, 32'h24, 32'h0, g);
        do3(1, 3'd2, 32'h2C, 32'h1111_1111, g);
        do3(0, 3'd2, 32'h10, 0, g); check("l3_lw_10", g, 32'hCAFE_F00D);
        do3(0, 3'd0, 32'h13, 0, g); check("l3_lb_13", g, 32'hFFFF_FFCA);
        do3(1, 3'd0, 32'h11, 32'h77, g);
        do3(0, 3'd5, 32'h10, 0, g); check("l3_lhu_10", g, 32'h0000_770D);
        do3(0, 3'd2, 32'h12, 0, g); check("l3_err", er3, 1);
        for (int t = 0; t < 20; t++)
            do3(1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                32'h10 + 32'($urandom_range(0, 3)), $urandom, g);

        model(1, 1, 3'd2, 32'h24, 32'h5A5A_A5A5, e, r);
        check("rdy3_sw", rdy3, 1);
        v3 = 1; we3 = 1; sz3 = 3'd2; ad3 = 32'h24; wd3 = 32'h5A5A_A5A5;
        @(posedge CLK); #1;
        rst3 = 1; ad3 = 32'h2C; wd3 = 32'hDEAD_BEEF;
        repeat (2) begin @(posedge CLK); #1; end
        rst3 = 0; v3 = 0;
        check("rsw_rdy", rdy3, 1);
        check("rsw_vld", rv3, 0);
        check("rsw_dat", rd3, 0);
        check("rsw_err", er3, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("rsw_novld", rv3, 0);
        end

        v3 = 1; we3 = 0; sz3 = 3'd2; ad3 = 32'h20;
        @(posedge CLK); #1;
        rst3 = 1; v3 = 0;
        @(posedge CLK); #1;
        rst3 = 0;
        check("rlw_rdy", rdy3, 1);
        check("rlw_vld", rv3, 0);
        check("rlw_dat", rd3, 0);
        check("rlw_err", er3, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("rlw_novld", rv3, 0);
        end

        do3(0, 3'd2, 32'h24, 0, g); check("l3_kept_24", g, 32'h5A5A_A5A5);
        do3(0, 3'd2, 32'h2C, 0, g); check("l3_kept_2c", g, 32'h1111_1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
